// File: rtl/pri_decoder_pipe_if.sv
// Handshake and status bundle for the priority decoder pipe.
// The master side feeds codes and drains words; the slave side is the decoder.
interface pri_decoder_pipe_if;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  binary_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] decoder_out;
  logic [1:0]  level;
  logic [7:0]  zero_cnt;

  modport master (
    output enable, in_valid, binary_in, out_ready,
    input  in_ready, out_valid, decoder_out, level, zero_cnt
  );

  modport slave (
    input  enable, in_valid, binary_in, out_ready,
    output in_ready, out_valid, decoder_out, level, zero_cnt
  );
endinterface

// File: rtl/pri_decoder_pipe.sv
// 4-bit code to one-hot decoder feeding a 2-entry FIFO with valid/ready on both sides.
// Words are decoded at push time; a saturating counter tallies accepted code-0 requests.
module pri_decoder_pipe (
  input  logic               clk,
  input  logic               reset_n,
  pri_decoder_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] head_word;
  logic [15:0] tail_word;
  logic [15:0] new_word;
  logic [7:0]  zero_count;
  logic        ready_ok;
  logic        push;
  logic        pop;

  // ready_ok keeps in_ready low while reset is held and until the first edge after release
  assign bus.in_ready    = ready_ok & bus.enable & (state != FULL);
  assign bus.out_valid   = (state != EMPTY);
  assign bus.decoder_out = bus.out_valid ? head_word : 16'h0000;
  assign bus.level       = state;
  assign bus.zero_cnt    = zero_count;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    new_word = 16'h0000;
    if (bus.binary_in != 4'd0)
      new_word = 16'(1) << bus.binary_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      head_word  <= 16'h0000;
      tail_word  <= 16'h0000;
      zero_count <= 8'd0;
      ready_ok   <= 1'b0;
    end else begin
      ready_ok <= 1'b1;
      if (push && (bus.binary_in == 4'd0) && (zero_count != 8'hFF))
        zero_count <= zero_count + 8'd1;
      case (state)
        EMPTY: begin
          if (push) begin
            head_word <= new_word;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_word <= new_word;
          end else if (push) begin
            tail_word <= new_word;
            state     <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_word <= tail_word;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
